// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encodings, bit-period
// derivation and the three-sample majority vote.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } rx_state_e;

    localparam int unsigned DEF_CLK_FREQ = 48_000_000;
    localparam int unsigned DEF_BAUD     = 3_000_000;

    // Number of system clocks in one bit period (16 at the defaults).
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Two-out-of-three vote used for every bit decision.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver.
// Handshake: a byte is transferred on every clk edge where rx_valid && rx_ready;
// rx_valid stays high and rx_data stays stable until that happens, and rx_ready
// has no effect while rx_valid is low. frame_err and overrun are one-cycle
// pulses that carry no handshake.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    // Receiver side drives the byte and status pulses.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side accepts bytes.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser that resets to 1 so an idle-high pin never looks
// like a falling edge coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the pin value through two stages.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchroniser register, reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RXD, detects the start edge, votes each bit
// at mid-period and hands bytes over through a one-entry valid/ready register.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rxd,
    uart_rx_if.master        rx_if,
    output rx_state_e        dbg_state
);

    // CLKS_PER_BIT must be at least 8 so the three vote samples fit in a bit.
    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);

    logic             rxd_s;
    logic             rxd_prev_q, rxd_prev_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             vote;
    logic             fall_edge;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // Vote combines the two stored samples with the live one at the decision point.
    always_comb begin
        vote      = majority3(samp_q[1], samp_q[0], rxd_s);
        fall_edge = rxd_prev_q & ~rxd_s;
    end

    // Capture the samples at H-1 and H that feed the vote at H+1.
    always_comb begin
        samp_d = samp_q;
        if (clk_cnt_q == CNT_PRE) begin
            samp_d[1] = rxd_s;
        end
        if (clk_cnt_q == CNT_MID) begin
            samp_d[0] = rxd_s;
        end
    end

    // Next-state logic: frame sequencing, shift register and holding register.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rxd_prev_d  = rxd_s;

        // Consumer takes the byte; a load below may immediately refill it.
        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (fall_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_DEC && vote) begin
                    // Start bit did not hold low: treat it as a glitch.
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                end else if (clk_cnt_q == CNT_LAST) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_DEC) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_DEC) begin
                    // Leave at mid stop bit so the next start edge is seen early.
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                    if (!vote) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_if.rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            samp_q      <= 2'b11;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_prev_q  <= rxd_prev_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are generated at the wire level, expected
// bytes go into a queue, and a monitor checks every handed-over byte.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB      = 16;
    localparam int H        = CPB / 2;
    // Two sync flops, one edge flop, nine bit periods up to the stop bit,
    // half a bit to its centre, then the vote and the output register.
    localparam int LAT      = 2 + 1 + 9 * CPB + H + 2;
    localparam int HALF_CLK = 10000;
    localparam real BIT_NOM  = 2.0 * HALF_CLK * CPB;
    localparam real BIT_FAST = BIT_NOM / 1.03;
    localparam real BIT_SLOW = BIT_NOM / 0.97;

    logic      clk;
    logic      rst_n;
    logic      uart_rxd;
    rx_state_e dbg_state;

    uart_rx_if rx_if ();

    uart_rx u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rx_if     (rx_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cycle = 0;

    initial begin
        clk = 1'b0;
        forever #(HALF_CLK) clk = ~clk;
    end

    always @(posedge clk) cycle++;

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_t_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err_count"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_overrun_count"}, 32'(ovr_cnt), 32'(exp_ovr));
        check({tag, "_pending_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // rx_ready: 0 = held low, 1 = held high, 2 = random.
    initial begin
        rx_if.rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) begin
                rx_if.rx_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rx_if.rx_ready = (ready_mode == 1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame. align starts the start bit just after a clock edge;
    // push records the byte (and its start cycle when lat_chk is set).
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input real bit_t,
                              input bit push, input bit lat_chk, input bit align);
        if (align) begin
            @(posedge clk);
            #1;
        end
        if (push) begin
            exp_q.push_back(d);
            exp_t_q.push_back(lat_chk ? cycle : -1);
        end
        uart_rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            #(bit_t);
        end
        uart_rxd = stop_ok;
        #(bit_t);
    endtask

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic [7:0] held = '0;
    int         rise_cycle = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_if.frame_err) ferr_cnt++;
            if (rx_if.overrun) ovr_cnt++;
            if (rx_if.rx_valid && !prev_valid) begin
                rise_cycle = cycle;
                held = rx_if.rx_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none at cycle %0d",
                             rx_if.rx_data, cycle);
                end
            end else if (rx_if.rx_valid) begin
                check("rx_data_stable", 32'(rx_if.rx_data), 32'(held));
            end
            if (rx_if.rx_valid && rx_if.rx_ready && exp_q.size() > 0) begin
                logic [7:0] e;
                int         t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("rx_data", 32'(rx_if.rx_data), 32'(e));
                if (t >= 0) begin
                    checks++;
                    if (rise_cycle - t < LAT - 1 || rise_cycle - t > LAT + 1) begin
                        errors++;
                        $display("FAIL latency actual=%0d expected=%0d+-1", rise_cycle - t, LAT);
                    end
                end
            end
            prev_valid = rx_if.rx_valid && !rx_if.rx_ready;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (100000) @(posedge clk);
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int n_pend;
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        idle(3);
        check("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_if.rx_data), 32'd0);
        check("reset_frame_err", 32'(rx_if.frame_err), 32'd0);
        check("reset_overrun", 32'(rx_if.overrun), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        idle(5);

        // Back-to-back frames with the consumer always ready.
        send_frame(8'h55, 1'b1, BIT_NOM, 1'b1, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, BIT_NOM, 1'b1, 1'b1, 1'b0);
        idle(40);
        check_counts("b2b");

        // Short low glitch on an idle line.
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        @(posedge clk);
        #2;
        check("glitch_in_start", 32'(dbg_state), 32'(S_START));
        repeat (9) @(posedge clk);
        #2;
        check("glitch_back_idle", 32'(dbg_state), 32'(S_IDLE));
        idle(30);
        check_counts("glitch");

        // Stop bit low, line held low afterwards, then a good frame.
        exp_ferr++;
        send_frame(8'h3C, 1'b0, BIT_NOM, 1'b0, 1'b0, 1'b1);
        idle(40);
        check("low_line_no_restart", 32'(dbg_state), 32'(S_IDLE));
        check("ferr_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        uart_rxd = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, BIT_NOM, 1'b1, 1'b1, 1'b1);
        idle(40);
        check_counts("ferr");

        // Consumer stalled: second byte overruns.
        @(negedge clk);
        ready_mode = 0;
        send_frame(8'h12, 1'b1, BIT_NOM, 1'b1, 1'b1, 1'b1);
        exp_ovr++;
        send_frame(8'h34, 1'b1, BIT_NOM, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("ovr_rx_valid_held", 32'(rx_if.rx_valid), 32'd1);
        check("ovr_rx_data_held", 32'(rx_if.rx_data), 32'h12);
        check("ovr_pulse_count", 32'(ovr_cnt), 32'(exp_ovr));
        @(negedge clk);
        ready_mode = 1;
        @(posedge clk);
        #2;
        check("ovr_ready_up", 32'(rx_if.rx_ready), 32'd1);
        @(posedge clk);
        #2;
        check("ovr_valid_drop", 32'(rx_if.rx_valid), 32'd0);
        idle(10);
        check_counts("ovr");

        // Reset during data bit 4 of 0xF0.
        fork
            send_frame(8'hF0, 1'b1, BIT_NOM, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 + CPB + 4 * CPB + H) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
                check("midrst_rx_data", 32'(rx_if.rx_data), 32'd0);
                check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
                check("midrst_frame_err", 32'(rx_if.frame_err), 32'd0);
                repeat (3) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        join
        idle(20);
        send_frame(8'h0F, 1'b1, BIT_NOM, 1'b1, 1'b1, 1'b1);
        idle(40);
        check_counts("midrst");

        // Transmitter running 3% fast and 3% slow.
        send_frame(8'hC3, 1'b1, BIT_FAST, 1'b1, 1'b0, 1'b1);
        idle(30);
        send_frame(8'hC3, 1'b1, BIT_SLOW, 1'b1, 1'b0, 1'b1);
        idle(30);
        check_counts("baud");

        // Random payloads, rates, stop errors, gaps and consumer stalls.
        @(negedge clk);
        ready_mode = 2;
        for (int k = 0; k < 14; k++) begin
            logic [7:0] d;
            bit         ok;
            int         rate;
            real        bt;
            d    = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 5) != 0);
            rate = $urandom_range(0, 2);
            bt   = (rate == 0) ? BIT_NOM : ((rate == 1) ? BIT_FAST : BIT_SLOW);
            if (!ok) exp_ferr++;
            send_frame(d, ok, bt, ok, (rate == 0), 1'b1);
            uart_rxd = 1'b1;
            idle($urandom_range(5, 30));
        end
        @(negedge clk);
        ready_mode = 1;

        n_pend = 0;
        while (exp_q.size() != 0 && n_pend < 2000) begin
            @(posedge clk);
            n_pend++;
        end
        idle(10);
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
